// File: rtl/wb_regfile.sv
// wb_regfile: writeback stage and 32x32-bit integer register file of the RV32I core.
//
// Selects the writeback value from the WB pipeline register, commits it to the
// architectural register file on the rising clock edge and counts committed writes.
//
// Ports:
//   clk            core clock, all state updates on the rising edge
//   reset          synchronous active-high reset (beats a concurrent write)
//   RegWEn_WB      register write enable from WB pipeline register
//   WBSel_WB       writeback select: 00 load data, 01 ALU result, 10 PC+4, 11 reserved
//   PCPlus4_WB     return address for JAL/JALR
//   rsW_WB         destination register index
//   Alu_out_WB     ALU result
//   Data_Load_WB   load data (already extended)
//   rs1_addr       read port 1 index
//   rs2_addr       read port 2 index
//   rs1_data       read port 1 data (combinational)
//   rs2_data       read port 2 data (combinational)
//   wb_data        selected writeback value (combinational, 0 for reserved select)
//   wb_commit      a write is committed at the next edge (combinational)
//   retire_count   registered count of committed writes, wraps silently
//
// Build option:
//   WB_BYPASS_EN   when defined, a read of the register being committed this cycle
//                  returns wb_data (write-through). When undefined, reads return
//                  stored contents only and no WB input reaches rs*_data.

module wb_regfile #(
  parameter logic [31:0] SP_RESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        RegWEn_WB,
  input  logic [1:0]  WBSel_WB,
  input  logic [31:0] PCPlus4_WB,
  input  logic [4:0]  rsW_WB,
  input  logic [31:0] Alu_out_WB,
  input  logic [31:0] Data_Load_WB,
  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  output logic [31:0] rs1_data,
  output logic [31:0] rs2_data,
  output logic [31:0] wb_data,
  output logic        wb_commit,
  output logic [31:0] retire_count
);

  logic [31:0] regs_q [32];
  logic [31:0] retire_q;
  logic [31:0] retire_d;

  // Writeback value select; reserved encoding yields 0.
  always_comb begin
    wb_data = '0;
    case (WBSel_WB)
      2'b00:   wb_data = Data_Load_WB;
      2'b01:   wb_data = Alu_out_WB;
      2'b10:   wb_data = PCPlus4_WB;
      default: wb_data = '0;
    endcase
  end

  assign wb_commit = RegWEn_WB && (rsW_WB != 5'd0) && (WBSel_WB != 2'b11) && !reset;

  assign retire_d     = wb_commit ? retire_q + 32'd1 : retire_q;
  assign retire_count = retire_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= (i == 2) ? SP_RESET : 32'h0;
      end
      retire_q <= '0;
    end else begin
      if (wb_commit) begin
        regs_q[rsW_WB] <= wb_data;
      end
      retire_q <= retire_d;
    end
  end

  always_comb begin
    rs1_data = '0;
    if (rs1_addr != 5'd0) begin
      rs1_data = regs_q[rs1_addr];
`ifdef WB_BYPASS_EN
      if (wb_commit && (rs1_addr == rsW_WB)) begin
        rs1_data = wb_data;
      end
`endif
    end
  end

  always_comb begin
    rs2_data = '0;
    if (rs2_addr != 5'd0) begin
      rs2_data = regs_q[rs2_addr];
`ifdef WB_BYPASS_EN
      if (wb_commit && (rs2_addr == rsW_WB)) begin
        rs2_data = wb_data;
      end
`endif
    end
  end

endmodule

// File: doc/wb_regfile.md
# wb_regfile

Writeback stage and integer register file of the 5-stage RV32I core. Consumes the WB pipeline register outputs, selects the writeback value, and commits it to the 32×32-bit architectural register file on the clock edge. Provides two read ports to the decode stage, with optional same-cycle write-through bypass, and a committed-write counter for debug and performance monitoring.

## Interface
- SP_RESET, 32'h0000_0000: reset value of x2 (stack pointer); all other registers reset to 0.
- clk  input  1  core clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- RegWEn_WB  input  1  register write enable from the WB pipeline register.
- WBSel_WB  input  2  writeback select: 00 = Data_Load_WB, 01 = Alu_out_WB, 10 = PCPlus4_WB, 11 = reserved.
- PCPlus4_WB  input  32  return address for JAL/JALR.
- rsW_WB  input  5  destination register index.
- Alu_out_WB  input  32  ALU result.
- Data_Load_WB  input  32  load data, already extended.
- rs1_addr  input  5  read port 1 index.
- rs2_addr  input  5  read port 2 index.
- rs1_data  output  32  read port 1 data, combinational.
- rs2_data  output  32  read port 2 data, combinational.
- wb_data  output  32  selected writeback value, combinational; 0 when WBSel_WB = 11.
- wb_commit  output  1  high when a write is committed at the next edge, combinational.
- retire_count  output  32  registered count of committed writes.

## Operation
- wb_commit = RegWEn_WB && (rsW_WB != 0) && (WBSel_WB != 2'b11) && !reset.
- On a rising edge with wb_commit high: regs[rsW_WB] <= wb_data and retire_count <= retire_count + 1.
- Writes to x0 are dropped. x0 always reads 0. Writes with WBSel_WB = 11 are dropped and not counted.
- retire_count wraps from 32'hFFFF_FFFF to 0 without a flag.
- Read ports:
  - Address 0 returns 0.
  - Otherwise each port returns regs[addr], subject to bypass (see Configuration).
  - Both ports may name the same register and must return identical data.
- Reset has priority over a concurrent write. While reset is high, all registers are cleared to 0, x2 is set to SP_RESET, and retire_count is set to 0.
- While reset is high, read ports return the stored (pre-reset) contents until the edge. They return reset values from the following cycle.

## Timing
- Write latency: a write presented in cycle N is stored at the end of cycle N. Unbypassed reads show it from cycle N+1.
- Reads have zero-cycle latency (combinational from rs*_addr and the WB inputs). No handshake; one write per cycle is accepted unconditionally.
- retire_count reflects a commit from cycle N in cycle N+1.
- Reset values: all registers 0 except x2 = SP_RESET; retire_count = 0. rs1_data, rs2_data, wb_data and wb_commit are combinational and follow their inputs. With all-zero inputs after reset, each of these outputs is 0.
- No combinational path from rs*_addr to wb_data or wb_commit.

## Configuration
- WB_BYPASS_EN defined:
  - When wb_commit is high and rsX_addr == rsW_WB, rsX_data returns wb_data in the same cycle (write-through).
  - The hazard unit needs no WB-to-ID forwarding or stall.
- WB_BYPASS_EN undefined:
  - Reads return stored contents only. A same-cycle read of the register being written returns the old value.
  - The hazard unit must stall decode for one cycle on that case.
  - No logic from the WB inputs reaches rs*_data.

## Test plan
- Reset, then read: assert reset 2 cycles with SP_RESET = 32'h0000_3FF0; read x2, x5 → rs1_data = 32'h0000_3FF0, rs2_data = 0, retire_count = 0.
- Writeback select: write x5 with WBSel_WB = 00/01/10, using Data_Load_WB = 32'hDEAD_BEEF, Alu_out_WB = 32'h0000_1234, PCPlus4_WB = 32'h0000_0104. Read next cycle → 32'hDEAD_BEEF, 32'h0000_1234, 32'h0000_0104 in turn; retire_count = 3.
- Dropped writes: RegWEn_WB = 1, rsW_WB = 0, Alu_out_WB = 32'hFFFF_FFFF → x0 reads 0. rsW_WB = 7 with WBSel_WB = 11 → x7 unchanged, wb_data = 0. retire_count unchanged in both cases.
- Same-cycle read/write: write x9 = 32'hA5A5_A5A5 while rs1_addr = rs2_addr = 9 and old x9 = 32'h1. With WB_BYPASS_EN both ports = 32'hA5A5_A5A5; without it both ports = 32'h1 that cycle and 32'hA5A5_A5A5 the next.
- Reset mid-write: reset = 1 with a valid write of x3 = 32'h55 → x3 = 0 and retire_count = 0 after the edge.
- Counter wrap: force 2^32 − 1 commits (or preload via hierarchical force to 32'hFFFF_FFFF), then 1 more commit → retire_count = 0.
